bsg_tag_stream_scheduler: RTL and testbench

- Generates the single-bit serial tag stream that drives bsg_tag_master_decentralized `data_i` pins.
- Arbitrates round-robin between num_req_p parallel packet requesters.
- Serializes each granted packet into start bit, header and payload.
- Emits the zero-run preamble that resets every downstream tag master after reset.

---
 rtl/bsg_tag_stream_scheduler.sv | 178 +++++++++++++++++
 tb/tb_bsg_tag_stream_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_tag_stream_scheduler.sv
// Round-robin scheduler that serializes tag packets into the bsg_tag_master data_i stream.
// Optional macro BSG_TAG_STREAM_SCHEDULER_RESYNC_EN adds resync_i to re-emit the preamble on demand.
module bsg_tag_stream_scheduler #(
    parameter int els_p         = 16,
    parameter int lg_width_p    = 4,
    parameter int num_req_p     = 2,
    parameter int reset_zeros_p = 64,
    parameter int gap_zeros_p   = 1,
    localparam int lg_els_lp    = (els_p <= 1) ? 1 : $clog2(els_p),
    localparam int max_len_lp   = (1 << lg_width_p) - 1
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [num_req_p-1:0]            v_i,
    input  logic [num_req_p*lg_els_lp-1:0]  node_id_i,
    input  logic [num_req_p-1:0]            data_not_reset_i,
    input  logic [num_req_p*lg_width_p-1:0] len_i,
    input  logic [num_req_p*max_len_lp-1:0] payload_i,
    output logic [num_req_p-1:0]            yumi_o,
    output logic                            tag_data_o,
    output logic                            busy_o
`ifdef BSG_TAG_STREAM_SCHEDULER_RESYNC_EN
    ,
    input  logic                            resync_i
`endif
);

    localparam int hw_lp      = lg_els_lp + 1 + lg_width_p;
    localparam int sr_w_lp    = hw_lp + max_len_lp;
    localparam int lg_req_lp  = (num_req_p <= 1) ? 1 : $clog2(num_req_p);
    localparam int max_a_lp   = (reset_zeros_p > gap_zeros_p) ? reset_zeros_p : gap_zeros_p;
    localparam int max_b_lp   = (hw_lp > max_len_lp) ? hw_lp : max_len_lp;
    localparam int max_cnt_lp = (max_a_lp > max_b_lp) ? max_a_lp : max_b_lp;
    localparam int cnt_w_lp   = $clog2(max_cnt_lp + 1) + 2;

    localparam logic [cnt_w_lp-1:0] reset_last_lp = cnt_w_lp'(reset_zeros_p - 1);
    localparam logic [cnt_w_lp-1:0] hdr_last_lp   = cnt_w_lp'(hw_lp - 1);
    localparam logic [cnt_w_lp-1:0] gap_last_lp   = cnt_w_lp'(gap_zeros_p - 1);

    typedef enum logic [2:0] {eReset, eIdle, eStart, eHeader, ePayload, eGap} state_e;

    state_e                  state_r, state_n;
    logic [cnt_w_lp-1:0]     cnt_r, cnt_n;
    logic [sr_w_lp-1:0]      sr_r, sr_n;
    logic [lg_width_p-1:0]   len_r, len_n;
    logic [lg_req_lp-1:0]    last_r, last_n;
    logic                    data_n;
    logic                    resync_req;

    logic [lg_els_lp-1:0]    node_arr [num_req_p];
    logic                    dnr_arr  [num_req_p];
    logic [lg_width_p-1:0]   len_arr  [num_req_p];
    logic [max_len_lp-1:0]   pay_arr  [num_req_p];

    for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
        assign node_arr[g] = node_id_i[g*lg_els_lp +: lg_els_lp];
        assign dnr_arr[g]  = data_not_reset_i[g];
        assign len_arr[g]  = len_i[g*lg_width_p +: lg_width_p];
        assign pay_arr[g]  = payload_i[g*max_len_lp +: max_len_lp];
    end

`ifdef BSG_TAG_STREAM_SCHEDULER_RESYNC_EN
    logic pend_r;

    // A resync seen while busy waits for the next idle slot
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            pend_r <= 1'b0;
        else if (state_r == eIdle)
            pend_r <= 1'b0;
        else if (resync_i)
            pend_r <= 1'b1;
    end

    assign resync_req = resync_i | pend_r;
`else
    assign resync_req = 1'b0;
`endif

    logic                 grant_v;
    logic [lg_req_lp-1:0] win, idx;

    always_comb begin
        grant_v = 1'b0;
        win     = last_r;
        idx     = '0;
        for (int i = 1; i <= num_req_p; i++) begin
            idx = lg_req_lp'((int'(last_r) + i) % num_req_p);
            if (!grant_v && v_i[idx]) begin
                grant_v = 1'b1;
                win     = idx;
            end
        end
    end

    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r + 1'b1;
        sr_n    = sr_r;
        len_n   = len_r;
        last_n  = last_r;
        data_n  = 1'b0;
        yumi_o  = '0;
        case (state_r)
            eReset: begin
                if (cnt_r == reset_last_lp) begin
                    cnt_n   = '0;
                    state_n = eIdle;
                end
            end
            eIdle: begin
                cnt_n = '0;
                if (resync_req) begin
                    state_n = eReset;
                end else if (grant_v) begin
                    yumi_o[win] = 1'b1;
                    sr_n        = {pay_arr[win], node_arr[win], dnr_arr[win], len_arr[win]};
                    len_n       = len_arr[win];
                    last_n      = win;
                    state_n     = eStart;
                end
            end
            eStart: begin
                data_n  = 1'b1;
                cnt_n   = '0;
                state_n = eHeader;
            end
            eHeader: begin
                data_n = sr_r[0];
                sr_n   = sr_r >> 1;
                if (cnt_r == hdr_last_lp) begin
                    cnt_n   = '0;
                    state_n = (len_r != '0) ? ePayload : eGap;
                end
            end
            // Header and payload share one shift register, so payload follows without realignment
            ePayload: begin
                data_n = sr_r[0];
                sr_n   = sr_r >> 1;
                if (cnt_r == cnt_w_lp'(len_r) - cnt_w_lp'(1)) begin
                    cnt_n   = '0;
                    state_n = eGap;
                end
            end
            eGap: begin
                if (cnt_r == gap_last_lp) begin
                    cnt_n   = '0;
                    state_n = eIdle;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = eReset;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r    <= eReset;
            cnt_r      <= '0;
            sr_r       <= '0;
            len_r      <= '0;
            last_r     <= lg_req_lp'(num_req_p - 1);
            tag_data_o <= 1'b0;
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            sr_r       <= sr_n;
            len_r      <= len_n;
            last_r     <= last_n;
            tag_data_o <= data_n;
        end
    end

    assign busy_o = (state_r != eIdle);

endmodule

// File: tb/tb_bsg_tag_stream_scheduler.sv
// Self-checking bench: queue-based stream model checked every cycle, plus directed literal checks.
module tb_bsg_tag_stream_scheduler;

    localparam int NumReq   = 2;
    localparam int LgEls    = 4;
    localparam int LgW      = 4;
    localparam int MaxLen   = 15;
    localparam int Preamble = 64;
    localparam int Gap      = 1;

    logic                     clk_i = 1'b0;
    logic                     reset_i;
    logic [NumReq-1:0]        v_i;
    logic [NumReq*LgEls-1:0]  node_id_i;
    logic [NumReq-1:0]        data_not_reset_i;
    logic [NumReq*LgW-1:0]    len_i;
    logic [NumReq*MaxLen-1:0] payload_i;
    logic [NumReq-1:0]        yumi_o;
    logic                     tag_data_o;
    logic                     busy_o;
    logic                     resync;

    bit                rq_v    [NumReq];
    logic [LgEls-1:0]  rq_node [NumReq];
    bit                rq_dnr  [NumReq];
    logic [LgW-1:0]    rq_len  [NumReq];
    logic [MaxLen-1:0] rq_pay  [NumReq];

    int checks = 0;
    int errors = 0;

    bsg_tag_stream_scheduler #(
        .els_p(16), .lg_width_p(LgW), .num_req_p(NumReq),
        .reset_zeros_p(Preamble), .gap_zeros_p(Gap)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .v_i(v_i),
        .node_id_i(node_id_i),
        .data_not_reset_i(data_not_reset_i),
        .len_i(len_i),
        .payload_i(payload_i),
        .yumi_o(yumi_o),
        .tag_data_o(tag_data_o),
        .busy_o(busy_o)
`ifdef BSG_TAG_STREAM_SCHEDULER_RESYNC_EN
        ,
        .resync_i(resync)
`endif
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        v_i              = '0;
        node_id_i        = '0;
        data_not_reset_i = '0;
        len_i            = '0;
        payload_i        = '0;
        for (int i = 0; i < NumReq; i++) begin
            v_i[i]                       = rq_v[i];
            node_id_i[i*LgEls +: LgEls]  = rq_node[i];
            data_not_reset_i[i]          = rq_dnr[i];
            len_i[i*LgW +: LgW]          = rq_len[i];
            payload_i[i*MaxLen +: MaxLen] = rq_pay[i];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input int r, input bit v, input logic [LgEls-1:0] node,
                                 input bit dnr, input logic [LgW-1:0] len, input logic [MaxLen-1:0] pay);
        rq_v[r]    = v;
        rq_node[r] = node;
        rq_dnr[r]  = dnr;
        rq_len[r]  = len;
        rq_pay[r]  = pay;
    endtask

    // Model: queue of bits still to be produced; empty queue means the scheduler is idle.
    bit pend_q [$];
    bit m_prev;
    bit m_resync;
    int m_last;

    always @(negedge clk_i) begin
        logic [NumReq-1:0] exp_yumi;
        int win;
        int idx;
        if (reset_i) begin
            checkOutput("reset_tag", tag_data_o, 0);
            checkOutput("reset_busy", busy_o, 1);
            checkOutput("reset_yumi", yumi_o, 0);
            pend_q.delete();
            repeat (Preamble) pend_q.push_back(1'b0);
            m_prev   = 1'b0;
            m_resync = 1'b0;
            m_last   = NumReq - 1;
        end else begin
            checkOutput("tag", tag_data_o, m_prev);
            checkOutput("busy", busy_o, pend_q.size() != 0);
            exp_yumi = '0;
            if (pend_q.size() != 0) begin
                m_prev = pend_q.pop_front();
                if (resync) m_resync = 1'b1;
            end else begin
                m_prev = 1'b0;
                if (resync || m_resync) begin
                    m_resync = 1'b0;
                    repeat (Preamble) pend_q.push_back(1'b0);
                end else begin
                    win = -1;
                    for (int k = 1; k <= NumReq; k++) begin
                        idx = (m_last + k) % NumReq;
                        if (win < 0 && rq_v[idx]) win = idx;
                    end
                    if (win >= 0) begin
                        exp_yumi[win] = 1'b1;
                        m_last = win;
                        pend_q.push_back(1'b1);
                        for (int i = 0; i < LgW; i++) pend_q.push_back(rq_len[win][i]);
                        pend_q.push_back(rq_dnr[win]);
                        for (int i = 0; i < LgEls; i++) pend_q.push_back(rq_node[win][i]);
                        for (int i = 0; i < int'(rq_len[win]); i++) pend_q.push_back(rq_pay[win][i]);
                        repeat (Gap) pend_q.push_back(1'b0);
                    end
                end
            end
            checkOutput("yumi", yumi_o, exp_yumi);
        end
    end

    task automatic waitIdle();
        int n = 0;
        @(negedge clk_i);
        while (busy_o && n < 500) begin
            n++;
            @(negedge clk_i);
        end
        checkOutput("idle_timeout", n < 500, 1);
    endtask

    initial begin
        int n;
        logic [3:0]  grants;
        logic [13:0] got14;
        logic [10:0] got11;

        reset_i = 1'b1;
        resync  = 1'b0;
        for (int i = 0; i < NumReq; i++) applyStimulus(i, 0, '0, 0, '0, '0);
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;

        // Preamble length: busy falls on the 64th cycle after release
        n = 0;
        @(negedge clk_i);
        while (busy_o && n < 200) begin
            n++;
            @(negedge clk_i);
        end
        checkOutput("preamble_len", n, 64);
        repeat (3) begin
            @(negedge clk_i);
            checkOutput("idle_tag", tag_data_o, 0);
        end

        // Both requesters always valid: grants alternate starting at 0
        @(posedge clk_i);
        #1;
        applyStimulus(0, 1, 4'd2, 1, 4'd2, 15'h0003);
        applyStimulus(1, 1, 4'd7, 0, 4'd2, 15'h0001);
        for (int g = 0; g < 4; g++) begin
            n = 0;
            @(negedge clk_i);
            while (yumi_o == '0 && n < 100) begin
                n++;
                @(negedge clk_i);
            end
            grants[3-g] = (n < 100) ? yumi_o[1] : 1'bx;
        end
        checkOutput("rr_order", grants, 4'b0101);
        @(posedge clk_i);
        #1;
        rq_v[0] = 0;
        rq_v[1] = 0;
        waitIdle();

        // nodeID 5, data op, len 3, payload 101
        @(posedge clk_i);
        #1 applyStimulus(0, 1, 4'd5, 1, 4'd3, 15'b101);
        @(negedge clk_i);
        checkOutput("t2_yumi", yumi_o, 2'b01);
        @(posedge clk_i);
        #1 rq_v[0] = 0;
        @(negedge clk_i);
        checkOutput("t2_yumi_once", yumi_o, 2'b00);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk_i);
            got14[i] = tag_data_o;
        end
        checkOutput("t2_stream", got14, 14'b01_0101_0110_0111);
        waitIdle();

        // len 0 packet held valid: stream then regrant right after the idle cycle
        @(posedge clk_i);
        #1 applyStimulus(1, 1, 4'd3, 0, 4'd0, 15'h7fff);
        @(negedge clk_i);
        checkOutput("t3_yumi", yumi_o, 2'b10);
        n = 0;
        got11 = '0;
        do begin
            @(negedge clk_i);
            n++;
            if (n >= 2 && n <= 12) got11[n-2] = tag_data_o;
        end while (yumi_o == '0 && n < 100);
        checkOutput("t3_stream", got11, 11'b000_1100_0001);
        checkOutput("t3_regrant_dist", n, 12);
        @(posedge clk_i);
        #1 rq_v[1] = 0;
        waitIdle();

        // Reset during payload bit 2 of a len 15 packet
        @(posedge clk_i);
        #1 applyStimulus(0, 1, 4'd9, 1, 4'd15, 15'h7fff);
        @(negedge clk_i);
        checkOutput("t5_yumi", yumi_o, 2'b01);
        @(posedge clk_i);
        #1 rq_v[0] = 0;
        repeat (12) @(posedge clk_i);
        #1 reset_i = 1'b1;
        @(negedge clk_i);
        checkOutput("t5_abort_tag", tag_data_o, 0);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        applyStimulus(1, 1, 4'd1, 1, 4'd1, 15'h1);
        // Reset-value zero, 64 preamble zeros, one idle zero, then the start bit
        n = 0;
        @(negedge clk_i);
        while (tag_data_o == 1'b0 && n < 200) begin
            n++;
            @(negedge clk_i);
        end
        checkOutput("t5_zeros_before_start", n, 66);
        @(posedge clk_i);
        #1 rq_v[1] = 0;
        waitIdle();

        // Randomized traffic with occasional reset (and resync when built in)
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk_i);
            #1;
            for (int r = 0; r < NumReq; r++)
                applyStimulus(r, $urandom_range(0, 2) != 0, 4'($urandom), 1'($urandom),
                              4'($urandom_range(0, 15)), 15'($urandom));
            reset_i = ($urandom_range(0, 999) == 0);
`ifdef BSG_TAG_STREAM_SCHEDULER_RESYNC_EN
            resync = ($urandom_range(0, 199) == 0);
`endif
        end
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        resync  = 1'b0;
        for (int r = 0; r < NumReq; r++) rq_v[r] = 0;
        repeat (5) @(posedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
